// File: rtl/ram_pkg.sv
// Shared types and helpers for the simple-dual-port sync-read RAM.
package ram_pkg;

    localparam int unsigned LANE_W = 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ram_state_e;

    function automatic int unsigned be_width(input int unsigned dwidth);
        return dwidth / LANE_W;
    endfunction

endpackage

// File: rtl/ram_byte_merge.sv
// Combinational byte-lane merge: lanes with be set take the new word, the rest keep the old word.
module ram_byte_merge
    import ram_pkg::*;
#(
    parameter  int unsigned DWIDTH  = 32,
    localparam int unsigned BEWIDTH = be_width(DWIDTH)
) (
    input  logic [DWIDTH-1:0]  old_i,
    input  logic [DWIDTH-1:0]  new_i,
    input  logic [BEWIDTH-1:0] be_i,
    output logic [DWIDTH-1:0]  merged_c_o
);

    always_comb begin
        merged_c_o = old_i;
        for (int i = 0; i < int'(BEWIDTH); i++) begin
            if (be_i[i]) begin
                merged_c_o[i*LANE_W +: LANE_W] = new_i[i*LANE_W +: LANE_W];
            end
        end
    end

endmodule

// File: rtl/ram_sync_read_dp.sv
// Simple-dual-port synchronous-read RAM with byte enables, selectable collision policy,
// optional output register and a zero-clear sequence after every reset.
module ram_sync_read_dp
    import ram_pkg::*;
#(
    parameter int unsigned AWIDTH  = 3,
    parameter int unsigned DWIDTH  = 32,
    parameter int unsigned OUT_REG = 0,
    parameter int unsigned BYPASS  = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [AWIDTH-1:0]             wr_addr,
    input  logic [DWIDTH-1:0]             wr_data,
    input  logic [be_width(DWIDTH)-1:0]   wr_be,
    input  logic                          rd_en,
    input  logic [AWIDTH-1:0]             rd_addr,
    output logic [DWIDTH-1:0]             rd_data,
    output logic                          rd_valid,
    output logic                          init_busy
);

    localparam int unsigned DEPTH   = 1 << AWIDTH;
    localparam int unsigned BEWIDTH = be_width(DWIDTH);
    localparam int unsigned CW      = AWIDTH + 1;

    ram_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;

    logic               mem_we_c;
    logic [AWIDTH-1:0]  mem_waddr_c;
    logic [DWIDTH-1:0]  mem_wdata_c;
    logic [BEWIDTH-1:0] mem_wbe_c;
    logic               rd_acc_c;

    logic [DWIDTH-1:0]  mem_q [DEPTH];
    logic [DWIDTH-1:0]  rd_old_c;
    logic [DWIDTH-1:0]  rd_merged_c;
    logic [DWIDTH-1:0]  rd_word_c;
    logic               collide_c;

    logic               rd_valid1_q;
    logic [DWIDTH-1:0]  rd_data1_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // INIT owns the write port to clear one word per clock; RUN hands both ports to the user.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        mem_we_c    = 1'b0;
        mem_waddr_c = wr_addr;
        mem_wdata_c = wr_data;
        mem_wbe_c   = wr_be;
        rd_acc_c    = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                mem_we_c    = 1'b1;
                mem_waddr_c = cnt_q[AWIDTH-1:0];
                mem_wdata_c = '0;
                mem_wbe_c   = '1;
                cnt_d       = cnt_q + CW'(1);
                if (cnt_q == CW'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b0;
                end
            end
            ST_RUN: begin
                mem_we_c = wr_en;
                rd_acc_c = rd_en;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (mem_we_c) begin
            for (int i = 0; i < int'(BEWIDTH); i++) begin
                if (mem_wbe_c[i]) begin
                    mem_q[mem_waddr_c][i*LANE_W +: LANE_W] <= mem_wdata_c[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    assign rd_old_c  = mem_q[rd_addr];
    assign collide_c = mem_we_c && (mem_waddr_c == rd_addr);

    ram_byte_merge #(
        .DWIDTH (DWIDTH)
    ) u_merge (
        .old_i      (rd_old_c),
        .new_i      (mem_wdata_c),
        .be_i       (mem_wbe_c),
        .merged_c_o (rd_merged_c)
    );

    // Write-first returns the merged word on a same-address collision; read-first keeps the old word.
    assign rd_word_c = ((BYPASS != 0) && collide_c) ? rd_merged_c : rd_old_c;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_valid1_q <= 1'b0;
            rd_data1_q  <= '0;
        end else begin
            rd_valid1_q <= rd_acc_c;
            if (rd_acc_c) begin
                rd_data1_q <= rd_word_c;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              rd_valid2_q;
            logic [DWIDTH-1:0] rd_data2_q;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    rd_valid2_q <= 1'b0;
                    rd_data2_q  <= '0;
                end else begin
                    rd_valid2_q <= rd_valid1_q;
                    if (rd_valid1_q) begin
                        rd_data2_q <= rd_data1_q;
                    end
                end
            end

            assign rd_valid = rd_valid2_q;
            assign rd_data  = rd_data2_q;
        end else begin : g_no_out_reg
            assign rd_valid = rd_valid1_q;
            assign rd_data  = rd_data1_q;
        end
    endgenerate

    assign init_busy = busy_q;

endmodule

// File: tb/tb_ram_sync_read_dp.sv
// Scoreboard bench: three RAM configurations driven with directed vectors, monitors compare on rd_valid.
module tb_ram_sync_read_dp;

    localparam int unsigned AW  = 3;
    localparam int unsigned DW  = 32;
    localparam int unsigned BW  = 4;
    localparam int unsigned SAW = 1;
    localparam int unsigned SDW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          wr_en = 1'b0, rd_en = 1'b0;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [BW-1:0] wr_be = '0;

    logic [DW-1:0] rd_data0, rd_data1;
    logic          rd_valid0, rd_valid1, busy0, busy1;

    logic           s_wr_en = 1'b0, s_rd_en = 1'b0;
    logic [SAW-1:0] s_wr_addr = '0, s_rd_addr = '0;
    logic [SDW-1:0] s_wr_data = '0;
    logic [0:0]     s_wr_be = '0;
    logic [SDW-1:0] s_rd_data;
    logic           s_rd_valid, s_busy;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0]  q0[$];
    logic [DW-1:0]  q1[$];
    logic [SDW-1:0] q2[$];

    always #5 clock = ~clock;

    // u0: latency 1, write-first.  u1: latency 2, read-first.  u2: tiny geometry.
    ram_sync_read_dp #(.AWIDTH(AW), .DWIDTH(DW), .OUT_REG(0), .BYPASS(1)) u0 (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
        .rd_valid(rd_valid0), .init_busy(busy0));

    ram_sync_read_dp #(.AWIDTH(AW), .DWIDTH(DW), .OUT_REG(1), .BYPASS(0)) u1 (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
        .rd_valid(rd_valid1), .init_busy(busy1));

    ram_sync_read_dp #(.AWIDTH(SAW), .DWIDTH(SDW), .OUT_REG(0), .BYPASS(1)) u2 (
        .clock(clock), .reset(reset), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .wr_be(s_wr_be), .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
        .rd_valid(s_rd_valid), .init_busy(s_busy));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic spurious(input string name, input logic [31:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: unexpected rd_valid with data %h, want no result", name, act);
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (rd_valid0) begin
                if (q0.size() == 0) spurious("u0 result", rd_data0);
                else check("u0 rd_data", rd_data0, q0.pop_front());
            end
            if (rd_valid1) begin
                if (q1.size() == 0) spurious("u1 result", rd_data1);
                else check("u1 rd_data", rd_data1, q1.pop_front());
            end
            if (s_rd_valid) begin
                if (q2.size() == 0) spurious("u2 result", 32'(s_rd_data));
                else check("u2 rd_data", 32'(s_rd_data), 32'(q2.pop_front()));
            end
        end
    end

    // One cycle of shared stimulus to u0/u1; e0/e1 are the per-policy expected read results.
    task automatic op(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [BW-1:0] be, input logic re, input logic [AW-1:0] ra,
                      input logic [DW-1:0] e0, input logic [DW-1:0] e1);
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_en = re; rd_addr = ra;
        if (re) begin
            q0.push_back(e0);
            q1.push_back(e1);
        end
        @(posedge clock); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic s_op(input logic we, input logic [SAW-1:0] wa, input logic [SDW-1:0] wd,
                        input logic re, input logic [SAW-1:0] ra, input logic [SDW-1:0] e);
        s_wr_en = we; s_wr_addr = wa; s_wr_data = wd; s_wr_be = 1'b1;
        s_rd_en = re; s_rd_addr = ra;
        if (re) q2.push_back(e);
        @(posedge clock); #1;
        s_wr_en = 1'b0; s_rd_en = 1'b0;
    endtask

    // Release reset and walk the clear sequence while hammering the ports with requests that must be ignored.
    task automatic run_init();
        reset = 1'b0;
        check("busy at release", 32'(busy0), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i - 1); wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
            rd_en = 1'b1; rd_addr = AW'(i - 1);
            if (i <= 2) begin
                s_wr_en = 1'b1; s_wr_addr = SAW'(i - 1); s_wr_data = 8'hFF; s_wr_be = 1'b1;
                s_rd_en = 1'b1; s_rd_addr = SAW'(i - 1);
            end
            @(posedge clock); #1;
            s_wr_en = 1'b0; s_rd_en = 1'b0;
            check($sformatf("u0 init_busy edge %0d", i), 32'(busy0), 32'(i < 8));
            check($sformatf("u1 init_busy edge %0d", i), 32'(busy1), 32'(i < 8));
            if (i <= 3) check($sformatf("u2 init_busy edge %0d", i), 32'(s_busy), 32'(i < 2));
        end
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        #2 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("reset init_busy", 32'(busy0), 32'd1);
        check("reset rd_valid", 32'(rd_valid1), 32'd0);
        check("reset rd_data", rd_data0, 32'd0);
        run_init();

        // Cleared contents, back-to-back reads of every address.
        for (int a = 0; a < 8; a++) op(1'b0, '0, '0, '0, 1'b1, AW'(a), 32'h0, 32'h0);

        // Byte-enable merge, plus be=0 no-op and a different-address concurrent write.
        op(1'b1, 3'd5, 32'hDEAD_BEEF, 4'b1111, 1'b0, '0, '0, '0);
        op(1'b1, 3'd5, 32'h1122_3344, 4'b0101, 1'b0, '0, '0, '0);
        op(1'b0, '0, '0, '0, 1'b1, 3'd5, 32'hDE22_BE44, 32'hDE22_BE44);
        op(1'b1, 3'd5, 32'hFFFF_FFFF, 4'b0000, 1'b0, '0, '0, '0);
        op(1'b1, 3'd6, 32'h0BAD_F00D, 4'b1111, 1'b1, 3'd5, 32'hDE22_BE44, 32'hDE22_BE44);
        op(1'b0, '0, '0, '0, 1'b1, 3'd6, 32'h0BAD_F00D, 32'h0BAD_F00D);

        // Same-address collision: write-first vs read-first, then the write is visible to both.
        op(1'b1, 3'd2, 32'hAAAA_AAAA, 4'b1111, 1'b0, '0, '0, '0);
        op(1'b1, 3'd2, 32'h5555_5555, 4'b0011, 1'b1, 3'd2, 32'hAAAA_5555, 32'hAAAA_AAAA);
        op(1'b0, '0, '0, '0, 1'b1, 3'd2, 32'hAAAA_5555, 32'hAAAA_5555);

        // Read latency and output-hold behaviour.
        op(1'b1, 3'd1, 32'h1, 4'hF, 1'b0, '0, '0, '0);
        op(1'b1, 3'd2, 32'h2, 4'hF, 1'b0, '0, '0, '0);
        op(1'b1, 3'd3, 32'h3, 4'hF, 1'b0, '0, '0, '0);
        repeat (3) @(posedge clock);
        #1;
        op(1'b0, '0, '0, '0, 1'b1, 3'd1, 32'h1, 32'h1);
        check("u0 valid after N", 32'(rd_valid0), 32'd1);
        check("u1 valid after N", 32'(rd_valid1), 32'd0);
        @(posedge clock); #1;
        check("u0 valid after N+1", 32'(rd_valid0), 32'd0);
        check("u1 valid after N+1", 32'(rd_valid1), 32'd1);
        op(1'b0, '0, '0, '0, 1'b1, 3'd1, 32'h1, 32'h1);
        op(1'b0, '0, '0, '0, 1'b1, 3'd2, 32'h2, 32'h2);
        op(1'b0, '0, '0, '0, 1'b1, 3'd3, 32'h3, 32'h3);
        repeat (3) @(posedge clock);
        #1;
        check("u1 hold rd_data", rd_data1, 32'h3);
        check("u1 hold rd_valid", 32'(rd_valid1), 32'd0);
        check("u0 hold rd_data", rd_data0, 32'h3);
        check("u0 hold rd_valid", 32'(rd_valid0), 32'd0);

        // Tiny geometry instance.
        s_op(1'b1, 1'b1, 8'hA5, 1'b0, '0, '0);
        s_op(1'b0, '0, '0, 1'b1, 1'b1, 8'hA5);
        s_op(1'b0, '0, '0, 1'b1, 1'b0, 8'h00);
        repeat (2) @(posedge clock);
        #1;

        // Reset lands while a read is in flight: no result, then the full clear repeats.
        rd_en = 1'b1; rd_addr = 3'd5;
        @(posedge clock); #1;
        rd_en = 1'b0;
        reset = 1'b1;
        #1;
        check("abort u0 rd_valid", 32'(rd_valid0), 32'd0);
        check("abort u1 rd_valid", 32'(rd_valid1), 32'd0);
        check("abort u1 rd_data", rd_data1, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        run_init();
        op(1'b0, '0, '0, '0, 1'b1, 3'd5, 32'h0, 32'h0);
        op(1'b0, '0, '0, '0, 1'b1, 3'd2, 32'h0, 32'h0);
        s_op(1'b0, '0, '0, 1'b1, 1'b1, 8'h00);

        repeat (4) @(posedge clock);
        #1;
        check("u0 results outstanding", 32'(q0.size()), 32'd0);
        check("u1 results outstanding", 32'(q1.size()), 32'd0);
        check("u2 results outstanding", 32'(q2.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_sync_read_dp.md
Name: ram_sync_read_dp

Overview:
- Parameterised simple-dual-port synchronous-read RAM: one write port and one read port with independent addresses, sharing one clock.
- Generalises the single-port sync-read data RAM with:
  - per-byte write enables
  - a configurable read-during-write policy
  - an optional output register stage with a read-valid flag
  - a hardware clear sequence after reset
- Sits between the cache/control FSMs and the data-array storage; replaces file-based preload with deterministic zero initialisation.

Parameters:
- AWIDTH, 3: address width; DEPTH = 1 << AWIDTH (localparam).
- DWIDTH, 32: data width; must be a multiple of 8. BEWIDTH = DWIDTH/8 (localparam).
- OUT_REG, 0: 0 = read latency 1; 1 = extra output register, read latency 2.
- BYPASS, 1: 1 = write-first on same-address collision; 0 = read-first (old data).

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-high reset.
- wr_en, input, 1: write request.
- wr_addr, input, AWIDTH: write address.
- wr_data, input, DWIDTH: write data.
- wr_be, input, BEWIDTH: byte enables; bit i gates wr_data[8i+7:8i].
- rd_en, input, 1: read request.
- rd_addr, input, AWIDTH: read address.
- rd_data, output, DWIDTH: read data.
- rd_valid, output, 1: rd_data holds the result of a read this cycle.
- init_busy, output, 1: clear sequence running; all requests are ignored.

Behaviour:
- Reset (async assert): init_busy=1, rd_valid=0, rd_data=0, clear counter=0, FSM=INIT, all pipeline valids cleared. Memory contents are not reset asynchronously.
- FSM INIT:
  - Each clock after reset deasserts, writes zero to mem[cnt] and increments cnt (AWIDTH+1 bits).
  - Exits when cnt reaches DEPTH-1, i.e. after exactly DEPTH write cycles.
  - In INIT, wr_en and rd_en are ignored, with no side effects.
  - The edge that clears the last word moves FSM to RUN and drops init_busy to 0.
- FSM RUN: stays in RUN until reset.
- Write (RUN, wr_en=1): for each i with wr_be[i]=1, mem[wr_addr] byte i <= wr_data byte i. Other bytes are unchanged. wr_be=0 is a legal no-op.
- Read (RUN, rd_en=1) at edge N:
  - OUT_REG=0: rd_data and rd_valid=1 appear after edge N, i.e. valid in cycle N+1.
  - OUT_REG=1: rd_data and rd_valid=1 appear after edge N+1.
  - rd_valid is exactly one cycle per accepted read. Back-to-back reads give one result per cycle.
- No read: rd_valid=0; rd_data holds its last value.
- Collision (wr_en & rd_en in the same cycle, wr_addr==rd_addr):
  - BYPASS=1: returns the byte-merged value, i.e. new bytes where wr_be=1, old bytes elsewhere.
  - BYPASS=0: returns the pre-write word.
  - Different addresses: no interaction.
- A write issued in cycle N is visible to any read issued in cycle N+1 or later, under both policies.
- Reset mid-operation (RUN or INIT):
  - Aborts any in-flight read; rd_valid=0 immediately.
  - Restarts INIT from cnt=0; the full DEPTH-cycle clear repeats.
- Address wrap: not applicable; addresses are full-range, and any AWIDTH value is legal.
- Storage must remain inferable as block RAM: write logic in a clocked block, read address or data registered.

Decomposition:
- Shared package ram_pkg:
  - FSM state encoding (INIT, RUN)
  - byte-lane width constant (8)
  - function computing BEWIDTH from DWIDTH
- Sub-module ram_byte_merge (combinational): takes old word, new word and wr_be; returns the merged word. Used by the bypass path, and reusable by the bench model.
- No further hierarchy.

Test Plan (AWIDTH=3, DWIDTH=32 unless noted):
1. Reset, then release:
   - init_busy=1 for exactly 8 clocks after deassertion, then 0.
   - Reading addr 0..7 returns 0x00000000 with rd_valid one cycle after each rd_en.
   - Requests issued during INIT have no effect.
2. Write 0xDEADBEEF to addr 5 with be=4'b1111, then write 0x11223344 to addr 5 with be=4'b0101, then read addr 5 → 0xDE22BE44.
3. Collision, BYPASS=1: mem[2]=0xAAAAAAAA; in the same cycle write 0x55555555 with be=4'b0011 and read addr 2 → 0xAAAA5555 next cycle. Repeat with BYPASS=0 → 0xAAAAAAAA.
4. OUT_REG=1: back-to-back reads of addr 1,2,3 (holding 0x1,0x2,0x3) → rd_valid high on cycles N+2..N+4 with data 0x1,0x2,0x3; rd_data holds 0x3 afterwards with rd_valid=0.
5. Reset mid-operation: assert reset one cycle after rd_en → rd_valid never asserts for that read. After the re-clear (8 cycles busy), previously written addr 5 reads 0x00000000.
6. Parameter sweep AWIDTH=1, DWIDTH=8: init takes 2 cycles; write 0xA5 to addr 1 then read → 0xA5.
